// File: rtl/wb_commit_stage.sv
// Writeback commit stage: merges load results (priority, no backpressure) and
// ALU results (valid/ready, in-order buffer) into one registered writeback packet.

package wb_commit_pkg;
    typedef struct packed {
        logic        wb_enable;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } rv32_mem2wb_packet_t;
endpackage

// Handshake: an ALU result transfers on a rising edge where alu_valid and alu_ready
// are both high; alu_ready depends only on registered occupancy, never on a same-cycle pop.
module wb_commit_stage
    import wb_commit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_data,
    input  logic                          ld_valid,
    input  logic [4:0]                    ld_rd,
    input  logic [31:0]                   ld_data,
    input  logic [4:0]                    query_rs1,
    input  logic [4:0]                    query_rs2,
    output logic                          rs1_pending,
    output logic                          rs2_pending,
    output rv32_mem2wb_packet_t           writeback_packet,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              ld_conflict_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    logic [4:0]          rd_mem_q   [FIFO_DEPTH];
    logic [31:0]         data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_FW-1:0]   count_q, count_d;
    logic [CNT_W-1:0]    conf_q, conf_d;
    rv32_mem2wb_packet_t pkt_q, pkt_d;

    logic alu_acc, alu_live, ld_live, fifo_empty;
    logic push, pop, conflict;
    logic [FIFO_DEPTH-1:0] ent_valid;
    logic rs1_hit, rs2_hit;

    assign alu_ready  = !reset && (count_q < CNT_FW'(FIFO_DEPTH));
    assign alu_acc    = alu_valid && alu_ready;
    assign alu_live   = alu_acc && (alu_rd != 5'd0);
    assign ld_live    = ld_valid && (ld_rd != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign conflict   = ld_live && (!fifo_empty || alu_live);

    always_comb begin
        pkt_d           = pkt_q;
        pkt_d.wb_enable = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        if (ld_live) begin
            pkt_d = '{wb_enable: 1'b1, wb_addr: ld_rd, wb_data: ld_data};
            push  = alu_live;
        end else if (!fifo_empty) begin
            pkt_d = '{wb_enable: 1'b1, wb_addr: rd_mem_q[rptr_q], wb_data: data_mem_q[rptr_q]};
            pop   = 1'b1;
            push  = alu_live;
        end else if (alu_live) begin
            pkt_d = '{wb_enable: 1'b1, wb_addr: alu_rd, wb_data: alu_data};
        end
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q + CNT_FW'(push) - CNT_FW'(pop);
        conf_d  = (conflict && (conf_q != '1)) ? conf_q + CNT_W'(1) : conf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            conf_q  <= '0;
        end else begin
            pkt_q   <= pkt_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            conf_q  <= conf_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            rd_mem_q[wptr_q]   <= alu_rd;
            data_mem_q[wptr_q] <= alu_data;
        end
    end

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_ent
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(g) - rptr_q;
        assign ent_valid[g] = {1'b0, off} < count_q;
    end

    always_comb begin
        rs1_hit = pkt_q.wb_enable && (pkt_q.wb_addr == query_rs1);
        rs2_hit = pkt_q.wb_enable && (pkt_q.wb_addr == query_rs2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (rd_mem_q[i] == query_rs1)) rs1_hit = 1'b1;
            if (ent_valid[i] && (rd_mem_q[i] == query_rs2)) rs2_hit = 1'b1;
        end
    end

    assign rs1_pending       = !reset && (query_rs1 != 5'd0) && rs1_hit;
    assign rs2_pending       = !reset && (query_rs2 != 5'd0) && rs2_hit;
    assign writeback_packet  = pkt_q;
    assign fifo_count        = count_q;
    assign ld_conflict_count = conf_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: vector table plus hand-written multi-cycle sequences.

module tb_wb_commit_stage;
    import wb_commit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_rd, ld_rd, query_rs1, query_rs2;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, rs1_pending, rs2_pending;
    logic        s_alu_ready, s_rs1_pending, s_rs2_pending;
    rv32_mem2wb_packet_t writeback_packet, s_writeback_packet;
    logic [2:0]  fifo_count, s_fifo_count;
    logic [15:0] ld_conflict_count;
    logic [3:0]  s_ld_conflict_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_commit_stage #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .writeback_packet(writeback_packet), .fifo_count(fifo_count),
        .ld_conflict_count(ld_conflict_count)
    );

    wb_commit_stage #(.FIFO_DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_pending(s_rs1_pending), .rs2_pending(s_rs2_pending),
        .writeback_packet(s_writeback_packet), .fifo_count(s_fifo_count),
        .ld_conflict_count(s_ld_conflict_count)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_rdy;
        logic        e_p1;
        logic        e_p2;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic [15:0] e_conf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ldata);
        reset     = rst;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adata;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wb_seen;
        logic [36:0] front;

        //            rst av ard  adata        lv lrd ldata         q1 q2  rdy p1 p2 en addr data          cnt conf
        vecs[0]  = '{1, 0, 0,  32'h0,        0, 0,  32'h0,        5, 0,  0, 0, 0, 0, 0,  32'h0,        0, 0};
        vecs[1]  = '{0, 1, 5,  32'h1234,     0, 0,  32'h0,        5, 0,  1, 0, 0, 1, 5,  32'h1234,     0, 0};
        vecs[2]  = '{0, 0, 0,  32'h0,        0, 0,  32'h0,        5, 0,  1, 1, 0, 0, 5,  32'h1234,     0, 0};
        vecs[3]  = '{0, 1, 7,  32'h77,       1, 3,  32'hAAAA0003, 7, 5,  1, 0, 0, 1, 3,  32'hAAAA0003, 1, 1};
        vecs[4]  = '{0, 0, 0,  32'h0,        0, 0,  32'h0,        7, 3,  1, 1, 1, 1, 7,  32'h77,       0, 1};
        vecs[5]  = '{0, 0, 0,  32'h0,        0, 0,  32'h0,        7, 0,  1, 1, 0, 0, 7,  32'h77,       0, 1};
        vecs[6]  = '{0, 1, 0,  32'hDEAD,     1, 0,  32'hBEEF,     0, 0,  1, 0, 0, 0, 7,  32'h77,       0, 1};
        vecs[7]  = '{0, 0, 0,  32'h0,        1, 9,  32'h99,       0, 9,  1, 0, 0, 1, 9,  32'h99,       0, 1};
        vecs[8]  = '{0, 1, 12, 32'hC,        1, 0,  32'h5,        9, 0,  1, 1, 0, 1, 12, 32'hC,        0, 1};
        vecs[9]  = '{0, 1, 0,  32'h44,       1, 10, 32'hA0,       0, 12, 1, 0, 1, 1, 10, 32'hA0,       0, 1};
        vecs[10] = '{1, 0, 0,  32'h0,        0, 0,  32'h0,        10, 0, 0, 0, 0, 0, 0,  32'h0,        0, 0};

        query_rs1 = 0;
        query_rs2 = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adata,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
            query_rs1 = vecs[i].q1;
            query_rs2 = vecs[i].q2;
            #1;
            check($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_rdy));
            check($sformatf("v%0d rs1_pending", i), 64'(rs1_pending), 64'(vecs[i].e_p1));
            check($sformatf("v%0d rs2_pending", i), 64'(rs2_pending), 64'(vecs[i].e_p2));
            step();
            check($sformatf("v%0d wb_enable", i), 64'(writeback_packet.wb_enable), 64'(vecs[i].e_en));
            check($sformatf("v%0d wb_addr", i), 64'(writeback_packet.wb_addr), 64'(vecs[i].e_addr));
            check($sformatf("v%0d wb_data", i), 64'(writeback_packet.wb_data), 64'(vecs[i].e_data));
            check($sformatf("v%0d fifo_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d conflict_count", i), 64'(ld_conflict_count), 64'(vecs[i].e_conf));
        end

        // Five back-to-back loads with the ALU offering every cycle.
        query_rs1 = 1;
        query_rs2 = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 5'(k + 1), 32'h2000 + k, 1, 5'(20 + k), 32'h1000 + k);
            #1;
            check($sformatf("fill%0d alu_ready", k), 64'(alu_ready), 64'(k < 4));
            if (k < 4) exp_q.push_back({5'(k + 1), 32'h2000 + k});
            step();
            check($sformatf("fill%0d wb_addr", k), 64'(writeback_packet.wb_addr), 64'(20 + k));
            check($sformatf("fill%0d wb_data", k), 64'(writeback_packet.wb_data), 64'(32'h1000 + k));
            check($sformatf("fill%0d fifo_count", k), 64'(fifo_count), 64'((k < 4) ? k + 1 : 4));
        end
        check("fill conflict_count", 64'(ld_conflict_count), 64'd5);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("drain alu_ready", 64'(alu_ready), 64'd0);
        check("drain rs1_pending", 64'(rs1_pending), 64'd1);
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            step();
            if (writeback_packet.wb_enable) begin
                front = exp_q.pop_front();
                check("drain order", {27'd0, writeback_packet.wb_addr, writeback_packet.wb_data},
                      {27'd0, front});
            end
        end
        check("drain leftover", 64'(exp_q.size()), 64'd0);
        check("drain fifo_count", 64'(fifo_count), 64'd0);

        // Reset while three ALU results are buffered.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 5'(k + 1), 32'h3000 + k, 1, 5'd20, 32'h55);
            step();
        end
        check("rst3 fifo_count", 64'(fifo_count), 64'd3);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst3 alu_ready", 64'(alu_ready), 64'd0);
        check("rst3 rs1_pending", 64'(rs1_pending), 64'd0);
        step();
        check("rst3 fifo_count after", 64'(fifo_count), 64'd0);
        check("rst3 wb_enable after", 64'(writeback_packet.wb_enable), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        wb_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (writeback_packet.wb_enable) wb_seen++;
        end
        check("rst3 stale writes", 64'(wb_seen), 64'd0);

        // Twenty conflict cycles: the 4-bit counter must stick at 0xF.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 5'd1, 32'h9, 1, 5'd20, 32'h8);
            step();
            if (k == 14) check("sat reach", 64'(s_ld_conflict_count), 64'hF);
        end
        check("sat hold", 64'(s_ld_conflict_count), 64'hF);
        check("wide conflict_count", 64'(ld_conflict_count), 64'd20);
        check("sat fifo_count full", 64'(s_fifo_count), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
